imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage. It handles all five RV base immediate formats (I, S, B, U, J) and sign-extends each to XLEN. It flags unsupported format selects and counts them in a saturating counter. One registered output stage plus a skid register give full-throughput valid/ready flow control between fetch/decode and the execute-side consumer.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64.
CNT_W, 8, width of the illegal-format counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; synchronous, active-high.
in_valid  input  1  upstream presents instr/imm_src.
in_ready  output  1  block can accept this cycle.
instr  input  32  raw instruction word.
imm_src  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J; 101–111 illegal.
out_valid  output  1  imm_out/imm_err hold a valid result.
out_ready  input  1  downstream accepts the result this cycle.
imm_out  output  XLEN  sign-extended immediate.
imm_err  output  1  result came from an illegal imm_src.
err_cnt  output  CNT_W  saturating count of accepted illegal selects.

Behaviour:
- Decode, combinational on the input side. Every 32-bit value below is sign-extended from instr[31] to XLEN.
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - Illegal select: imm = 0, err = 1. Legal select: err = 0.
- Storage: main register M drives the out_* ports. Skid register S holds one overflow entry. Each has its own valid bit.
- Handshakes:
  - in_ready = !S.valid, and is forced 0 while rst is high.
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - out_valid = M.valid.
- Per cycle, when out_fire or !M.valid:
  - If S.valid: M <= S and S.valid <= 0. in_fire is impossible because in_ready = 0.
  - Else if in_fire: M <= decode(input).
  - Else: M.valid <= 0. imm_out and imm_err keep their last value.
- Per cycle, when M.valid and !out_ready: if in_fire, S <= decode(input). M holds.
- Guarantees:
  - Latency is 1 cycle from in_fire to out_valid when not stalled.
  - Sustained throughput is 1 result per cycle.
  - Results leave in acceptance order.
  - Out data stays stable while out_valid & !out_ready.
- err_cnt increments by 1 on each in_fire with an illegal imm_src. It saturates at 2^CNT_W−1 and never wraps. It is counted at acceptance, not at output.
- Simultaneous events:
  - out_fire with S empty and in_fire: M is replaced by the new result in the same edge, giving no bubble.
  - out_fire with S full: S moves to M, and in_ready rises the following cycle.
- Reset (synchronous) clears M.valid, S.valid, imm_out, imm_err and err_cnt to 0, including mid-stall. Data pending in M or S is discarded. in_ready is 1 on the first cycle after rst deasserts.
- instr and imm_src are sampled only on in_fire. They are don't-care otherwise.

Test Plan:
1. I and XLEN:
   - XLEN=32, instr=0xFFF00093, imm_src=000, out_ready=1 → next cycle out_valid=1, imm_out=0xFFFFFFFF, imm_err=0.
   - Same stimulus with XLEN=64 → imm_out=0xFFFFFFFFFFFFFFFF.
2. B, S, U, J formats:
   - B: 0xFE000EE3 → 0xFFFFFFFC.
   - S (sw x2,-8(x1)): 0xFE20AC23 → 0xFFFFFFF8.
   - U: 0x123452B7 → 0x12345000.
   - J: 0x0080006F → 0x00000008.
   - Applied back-to-back, these give four consecutive output cycles in order.
3. Backpressure:
   - Drive out_ready=0 and present A, B, C on consecutive cycles.
   - Required: A held on the output; B captured in S; in_ready=0 from the cycle after B is accepted; C held by the source.
   - Then raise out_ready → outputs A, B, C on consecutive cycles with no loss or duplication.
4. Illegal select:
   - imm_src=111, any instr → imm_out=0, imm_err=1, err_cnt=1.
   - With CNT_W=2, five illegal acceptances → err_cnt=3, which holds.
5. Reset mid-operation: with M and S full and out_ready=0, assert rst one cycle → out_valid=0, err_cnt=0, in_ready=1 on the next cycle, and no stale result is emitted.
6. Random stress: random in_valid/out_ready and legal/illegal selects against a reference decoder plus FIFO model → every accepted input emerges exactly once, in order, with matching imm_out/imm_err, and err_cnt matches the model.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator: combinational decode of I/S/B/U/J formats,
// one output register plus one skid register, and a saturating illegal-select counter.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic             imm_err,
  output logic [CNT_W-1:0] err_cnt
);

  function automatic logic signed [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  logic signed [XLEN-1:0] dec_imm;
  logic                   dec_err;

  logic                   m_vld_q, m_vld_d;
  logic signed [XLEN-1:0] m_imm_q, m_imm_d;
  logic                   m_err_q, m_err_d;
  logic                   s_vld_q, s_vld_d;
  logic signed [XLEN-1:0] s_imm_q, s_imm_d;
  logic                   s_err_q, s_err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic in_fire, out_fire, advance;

  // Input side: decode of the presented instruction
  always_comb begin
    dec_imm = '0;
    dec_err = 1'b0;
    case (imm_src)
      3'b000:  dec_imm = sext32({{20{instr[31]}}, instr[31:20]});
      3'b001:  dec_imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
      3'b010:  dec_imm = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                 instr[11:8], 1'b0});
      3'b011:  dec_imm = sext32({instr[31:12], 12'b0});
      3'b100:  dec_imm = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                 instr[30:21], 1'b0});
      default: dec_err = 1'b1;
    endcase
  end

  assign in_ready  = !s_vld_q && !rst;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = m_vld_q && out_ready;
  assign advance   = out_fire || !m_vld_q;

  always_comb begin
    m_vld_d = m_vld_q;
    m_imm_d = m_imm_q;
    m_err_d = m_err_q;
    s_vld_d = s_vld_q;
    s_imm_d = s_imm_q;
    s_err_d = s_err_q;
    cnt_d   = cnt_q;
    if (advance) begin
      if (s_vld_q) begin
        m_vld_d = 1'b1;
        m_imm_d = s_imm_q;
        m_err_d = s_err_q;
        s_vld_d = 1'b0;
      end else if (in_fire) begin
        m_vld_d = 1'b1;
        m_imm_d = dec_imm;
        m_err_d = dec_err;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      // Output stalled: park the new result in the skid slot
      s_vld_d = 1'b1;
      s_imm_d = dec_imm;
      s_err_d = dec_err;
    end
    if (in_fire && dec_err) cnt_d = sat_inc(cnt_q);
  end

  // Output stage and skid control
  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld_q <= 1'b0;
      m_imm_q <= '0;
      m_err_q <= 1'b0;
      s_vld_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      m_vld_q <= m_vld_d;
      m_imm_q <= m_imm_d;
      m_err_q <= m_err_d;
      s_vld_q <= s_vld_d;
      cnt_q   <= cnt_d;
    end
  end

  // Skid payload is qualified by s_vld_q, so it needs no reset
  always_ff @(posedge clk) begin
    s_imm_q <= s_imm_d;
    s_err_q <= s_err_d;
  end

  assign out_valid = m_vld_q;
  assign imm_out   = m_imm_q;
  assign imm_err   = m_err_q;
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit/8-bit-counter instance and a 64-bit/2-bit-counter
// instance share stimulus and are checked against a field-arithmetic model and a queue.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [2:0]  imm_src = '0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid, a_imm_err;
  logic [31:0] a_imm_out;
  logic [7:0]  a_err_cnt;
  logic        b_in_ready, b_out_valid, b_imm_err;
  logic [63:0] b_imm_out;
  logic [1:0]  b_err_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] imm;
    logic        err;
  } ent_t;

  imm_gen_pipe #(.XLEN(32), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .instr(instr), .imm_src(imm_src), .out_valid(a_out_valid), .out_ready(out_ready),
    .imm_out(a_imm_out), .imm_err(a_imm_err), .err_cnt(a_err_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .instr(instr), .imm_src(imm_src), .out_valid(b_out_valid), .out_ready(out_ready),
    .imm_out(b_imm_out), .imm_err(b_imm_err), .err_cnt(b_err_cnt)
  );

  always #5 clk = ~clk;

  // Reference decoder: immediate value built from instruction fields with plain arithmetic
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src);
    longint x, r;
    x = longint'($signed(ins));
    case (src)
      3'd0: r = x >>> 20;
      3'd1: r = ((x >>> 25) <<< 5) | longint'(ins[11:7]);
      3'd2: r = ((x >>> 31) <<< 12) | (longint'(ins[7]) << 11) |
                (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
      3'd3: r = (x >>> 12) <<< 12;
      3'd4: r = ((x >>> 31) <<< 20) | (longint'(ins[19:12]) << 12) |
                (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
      default: r = 0;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_during got=%b exp=0", a_in_ready); end
    checks++; if (a_imm_out !== 32'h0 || a_imm_err !== 1'b0) begin failures++; $display("FAIL reset_data got=%h/%b exp=0/0", a_imm_out, a_imm_err); end
    checks++; if (a_err_cnt !== 8'h0 || b_err_cnt !== 2'h0) begin failures++; $display("FAIL reset_err_cnt got=%0d/%0d exp=0/0", a_err_cnt, b_err_cnt); end
    rst = 1'b0;
    #1;
    checks++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_after got=%b/%b exp=1", a_in_ready, b_in_ready); end
  endtask

  task automatic test_i_format();
    in_valid = 1'b1; instr = 32'hFFF00093; imm_src = 3'b000; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL i_out_valid got=%b exp=1", a_out_valid); end
    checks++; if (a_imm_out !== 32'hFFFFFFFF || a_imm_err !== 1'b0) begin failures++; $display("FAIL i_imm32 got=%h/%b exp=ffffffff/0", a_imm_out, a_imm_err); end
    checks++; if (b_imm_out !== 64'hFFFFFFFFFFFFFFFF) begin failures++; $display("FAIL i_imm64 got=%h exp=ffffffffffffffff", b_imm_out); end
    tick();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL i_drain got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [4] = '{32'hFE000EE3, 32'hFE20AC23, 32'h123452B7, 32'h0080006F};
    logic [2:0]  src [4] = '{3'd2, 3'd1, 3'd3, 3'd4};
    logic [63:0] exp [4] = '{64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                             64'h0000000012345000, 64'h0000000000000008};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; instr = ins[i]; imm_src = src[i];
      tick();
      checks++; if (a_out_valid !== 1'b1 || a_imm_out !== exp[i][31:0]) begin failures++; $display("FAIL fmt%0d_imm32 got=%b/%h exp=1/%h", i, a_out_valid, a_imm_out, exp[i][31:0]); end
      checks++; if (b_imm_out !== exp[i] || b_imm_err !== 1'b0) begin failures++; $display("FAIL fmt%0d_imm64 got=%h/%b exp=%h/0", i, b_imm_out, b_imm_err, exp[i]); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] ia = 32'h00100093, ib = 32'hABCDE037, ic = 32'h80000013;
    out_ready = 1'b0;
    in_valid = 1'b1; instr = ia; imm_src = 3'd0;
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_imm_out !== 32'h1 || a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_A got=%b/%h/%b exp=1/00000001/1", a_out_valid, a_imm_out, a_in_ready); end
    instr = ib; imm_src = 3'd3;
    tick();
    checks++; if (a_in_ready !== 1'b0 || a_imm_out !== 32'h1) begin failures++; $display("FAIL bp_B_skid got=%b/%h exp=0/00000001", a_in_ready, a_imm_out); end
    instr = ic; imm_src = 3'd0;
    tick();
    checks++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_imm_out !== 32'h1) begin failures++; $display("FAIL bp_hold got=%b/%b/%h exp=0/1/00000001", a_in_ready, a_out_valid, a_imm_out); end
    out_ready = 1'b1;
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_imm_out !== 32'hABCDE000 || a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_outB got=%b/%h/%b exp=1/abcde000/1", a_out_valid, a_imm_out, a_in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1 || a_imm_out !== 32'hFFFFF800) begin failures++; $display("FAIL bp_outC got=%b/%h exp=1/fffff800", a_out_valid, a_imm_out); end
    checks++; if (b_imm_out !== 64'hFFFFFFFFFFFFF800) begin failures++; $display("FAIL bp_outC64 got=%h exp=fffffffffffff800", b_imm_out); end
    tick();
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%b exp=0", a_out_valid); end
  endtask

  task automatic test_illegal();
    logic [2:0] srcs [5] = '{3'd7, 3'd5, 3'd6, 3'd7, 3'd5};
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1; instr = $urandom; imm_src = srcs[k-1];
      tick();
      checks++; if (a_imm_out !== 32'h0 || a_imm_err !== 1'b1 || b_imm_out !== 64'h0) begin failures++; $display("FAIL ill%0d_out got=%h/%b/%h exp=0/1/0", k, a_imm_out, a_imm_err, b_imm_out); end
      checks++; if (a_err_cnt !== 8'(k) || b_err_cnt !== 2'((k > 3) ? 3 : k)) begin failures++; $display("FAIL ill%0d_cnt got=%0d/%0d exp=%0d/%0d", k, a_err_cnt, b_err_cnt, k, (k > 3) ? 3 : k); end
    end
    instr = 32'h00500093; imm_src = 3'd0;
    tick();
    in_valid = 1'b0;
    checks++; if (a_imm_err !== 1'b0 || a_imm_out !== 32'h5 || b_err_cnt !== 2'd3 || a_err_cnt !== 8'd5) begin failures++; $display("FAIL ill_hold got=%b/%h/%0d/%0d exp=0/00000005/3/5", a_imm_err, a_imm_out, b_err_cnt, a_err_cnt); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h00700093; imm_src = 3'd0;
    tick();
    imm_src = 3'd6;
    tick();
    checks++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin failures++; $display("FAIL rm_full got=%b/%b exp=0/1", a_in_ready, a_out_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_err_cnt !== 8'd0 || b_err_cnt !== 2'd0) begin failures++; $display("FAIL rm_cleared got=%b/%0d/%0d exp=0/0/0", a_out_valid, a_err_cnt, b_err_cnt); end
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL rm_in_ready got=%b exp=1", a_in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rm_stale%0d got=%b exp=0", i, a_out_valid); end
    end
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t e;
    int cnt_a = 0, cnt_b = 0;
    logic exp_rdy, in_fire, out_fire;
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      instr     = $urandom;
      imm_src   = 3'($urandom_range(0, 7));
      #1;
      exp_rdy = (q.size() < 2);
      checks++; if (a_in_ready !== exp_rdy) begin failures++; $display("FAIL rnd%0d_in_ready got=%b exp=%b", cyc, a_in_ready, exp_rdy); end
      checks++; if (a_out_valid !== (q.size() > 0)) begin failures++; $display("FAIL rnd%0d_out_valid got=%b exp=%b", cyc, a_out_valid, q.size() > 0); end
      if (q.size() > 0) begin
        checks++; if (a_imm_out !== q[0].imm[31:0] || a_imm_err !== q[0].err || b_imm_out !== q[0].imm || b_imm_err !== q[0].err) begin failures++; $display("FAIL rnd%0d_data got=%h/%b/%h exp=%h/%b", cyc, a_imm_out, a_imm_err, b_imm_out, q[0].imm, q[0].err); end
      end
      checks++; if (a_err_cnt !== 8'(cnt_a) || b_err_cnt !== 2'(cnt_b)) begin failures++; $display("FAIL rnd%0d_cnt got=%0d/%0d exp=%0d/%0d", cyc, a_err_cnt, b_err_cnt, cnt_a, cnt_b); end
      in_fire  = in_valid && exp_rdy;
      out_fire = (q.size() > 0) && out_ready;
      if (out_fire) void'(q.pop_front());
      if (in_fire) begin
        e.imm = ref_imm(instr, imm_src);
        e.err = (imm_src > 3'd4);
        q.push_back(e);
        if (e.err) begin
          if (cnt_a < 255) cnt_a++;
          if (cnt_b < 3) cnt_b++;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_i_format();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
